// File: rtl/joypad_port_sequencer_pkg.sv
// Shared NES joypad definitions: register addresses, button bit order, and per-port sequencer states.
package nes_pkg;
  localparam logic [15:0] JOY1_ADDR = 16'h4016;
  localparam logic [15:0] JOY2_ADDR = 16'h4017;

  typedef enum logic [2:0] {
    BTN_A, BTN_B, BTN_SELECT, BTN_START, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT
  } btn_e;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} joy_state_e;

  // Bit counter saturates once the shift register is fully filled.
  function automatic logic [3:0] sat_inc8(input logic [3:0] cnt);
    return (cnt >= 4'd8) ? 4'd8 : cnt + 4'd1;
  endfunction
endpackage

// File: rtl/joypad_port_sequencer_if.sv
// CPU-bus and NIOS keycode signals for the joypad sequencer.
interface joypad_port_sequencer_if;
  logic       cs_4016;
  logic       cs_4017;
  logic       rden;
  logic       wren;
  logic [7:0] data_in;
  logic [7:0] open_bus_in;
  logic [7:0] kc_p1;
  logic [7:0] kc_p2;
  logic       kc_valid;
  logic [7:0] data_out;
  logic       strobe_out;

  modport master (
    output cs_4016, cs_4017, rden, wren, data_in, open_bus_in, kc_p1, kc_p2, kc_valid,
    input  data_out, strobe_out
  );

  modport slave (
    input  cs_4016, cs_4017, rden, wren, data_in, open_bus_in, kc_p1, kc_p2, kc_valid,
    output data_out, strobe_out
  );
endinterface

// File: rtl/joypad_port_sequencer_shift.sv
// One joypad port: strobe-driven parallel load, then one shift per read pulse with fill-bit backfill.
module joypad_shift
  import nes_pkg::*;
#(
  parameter logic FILL_BIT = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_strobe,
  input  logic [7:0] i_snap,
  input  logic       i_rd_pulse,
  output logic       o_read_bit
);
  joy_state_e r_state, w_state_nxt;
  logic [7:0] r_sr, w_sr_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_sr    <= 8'h00;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_sr_nxt = 8'h00;
        if (i_strobe) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_sr_nxt  = i_snap;
        w_cnt_nxt = 4'd0;
        if (!i_strobe) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (i_rd_pulse) begin
          w_sr_nxt  = {FILL_BIT, r_sr[7:1]};
          w_cnt_nxt = sat_inc8(r_cnt);
        end
        if (i_strobe) w_state_nxt = LOAD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // While loading, sr trails the snapshot by a cycle, so read button A straight from it.
  assign o_read_bit = (r_state == LOAD) ? i_snap[BTN_A] : r_sr[0];
endmodule

// File: rtl/joypad_port_sequencer.sv
// $4016/$4017 joypad front end: access edge detect, strobe latch, keycode snapshots, read-data mux.
module joypad_port_sequencer
  import nes_pkg::*;
#(
  parameter logic       FILL_BIT      = 1'b1,
  parameter logic [7:0] OPEN_BUS_MASK = 8'hE0
) (
  input logic                   i_clk,
  input logic                   i_reset,
  joypad_port_sequencer_if.slave io_bus
);
  logic       r_rd1_q, r_rd2_q, r_wr_q;
  logic       r_strobe;
  logic [7:0] r_snap_p1, r_snap_p2;
  logic [7:0] r_data_out;
  logic       w_rd1_lvl, w_rd2_lvl, w_wr_lvl;
  logic       w_rd1_pulse, w_rd2_pulse, w_wr_pulse;
  logic       w_bit_p1, w_bit_p2;
  logic [7:0] w_ob_bits;

  assign w_rd1_lvl   = io_bus.rden & io_bus.cs_4016;
  assign w_rd2_lvl   = io_bus.rden & io_bus.cs_4017;
  assign w_wr_lvl    = io_bus.wren & io_bus.cs_4016;
  assign w_rd1_pulse = w_rd1_lvl & ~r_rd1_q;
  assign w_rd2_pulse = w_rd2_lvl & ~r_rd2_q;
  assign w_wr_pulse  = w_wr_lvl & ~r_wr_q;
  assign w_ob_bits   = io_bus.open_bus_in & OPEN_BUS_MASK & 8'hFE;

  // Reads sample sr before any strobe change from the same RMW cycle takes effect.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd1_q    <= 1'b0;
      r_rd2_q    <= 1'b0;
      r_wr_q     <= 1'b0;
      r_strobe   <= 1'b0;
      r_snap_p1  <= 8'h00;
      r_snap_p2  <= 8'h00;
      r_data_out <= 8'h00;
    end else begin
      r_rd1_q <= w_rd1_lvl;
      r_rd2_q <= w_rd2_lvl;
      r_wr_q  <= w_wr_lvl;
      if (w_wr_pulse) r_strobe <= io_bus.data_in[0];
      if (io_bus.kc_valid) begin
        r_snap_p1 <= io_bus.kc_p1;
        r_snap_p2 <= io_bus.kc_p2;
      end
      if (w_rd1_pulse)      r_data_out <= w_ob_bits | {7'b0, w_bit_p1};
      else if (w_rd2_pulse) r_data_out <= w_ob_bits | {7'b0, w_bit_p2};
    end
  end

  joypad_shift #(.FILL_BIT(FILL_BIT)) u_p1 (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_strobe   (r_strobe),
    .i_snap     (r_snap_p1),
    .i_rd_pulse (w_rd1_pulse),
    .o_read_bit (w_bit_p1)
  );

  joypad_shift #(.FILL_BIT(FILL_BIT)) u_p2 (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_strobe   (r_strobe),
    .i_snap     (r_snap_p2),
    .i_rd_pulse (w_rd2_pulse),
    .o_read_bit (w_bit_p2)
  );

  assign io_bus.data_out   = r_data_out;
  assign io_bus.strobe_out = r_strobe;
endmodule

// File: tb/tb_joypad_port_sequencer.sv
// Randomized and directed checks of the joypad sequencer against a button-list model of the pad protocol.
module tb_joypad_port_sequencer;
  import nes_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  joypad_port_sequencer_if bus();

  joypad_port_sequencer #(.FILL_BIT(1'b1), .OPEN_BUS_MASK(8'hE0)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  // Model: a pad reports its latched buttons in order A..Right, then 1s; strobe high reports live A.
  logic       m_strobe;
  logic       m_armed;
  logic [7:0] m_snap    [2];
  logic [7:0] m_latched [2];
  int         m_reads   [2];

  function automatic logic model_read(input int p);
    logic b;
    if (m_strobe)      b = m_snap[p][0];
    else if (!m_armed) b = 1'b0;
    else begin
      b = (m_reads[p] < 8) ? m_latched[p][m_reads[p]] : 1'b1;
      m_reads[p]++;
    end
    return b;
  endfunction

  function automatic void model_write(input logic v);
    if (m_strobe && !v) begin
      for (int p = 0; p < 2; p++) begin
        m_latched[p] = m_snap[p];
        m_reads[p]   = 0;
      end
    end
    if (v) m_armed = 1'b1;
    m_strobe = v;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    m_strobe = 1'b0; m_armed = 1'b0;
    m_snap[0] = 8'h00; m_snap[1] = 8'h00;
    m_latched[0] = 8'h00; m_latched[1] = 8'h00;
    m_reads[0] = 0; m_reads[1] = 0;
    idle(1);
  endtask

  task automatic do_write(input logic cs17, input logic [7:0] d);
    bus.cs_4016 = !cs17; bus.cs_4017 = cs17; bus.wren = 1'b1; bus.data_in = d;
    idle(1);
    bus.cs_4016 = 1'b0; bus.cs_4017 = 1'b0; bus.wren = 1'b0;
    if (!cs17) model_write(d[0]);
    idle(2);
  endtask

  task automatic do_kc(input logic [7:0] k1, input logic [7:0] k2);
    bus.kc_p1 = k1; bus.kc_p2 = k2; bus.kc_valid = 1'b1;
    idle(1);
    bus.kc_valid = 1'b0;
    m_snap[0] = k1; m_snap[1] = k2;
    idle(1);
  endtask

  task automatic do_read(input int port, input int hold, input logic [7:0] ob,
                         output logic [7:0] got);
    bus.open_bus_in = ob;
    bus.cs_4016 = (port == 0); bus.cs_4017 = (port == 1); bus.rden = 1'b1;
    idle(hold);
    bus.rden = 1'b0; bus.cs_4016 = 1'b0; bus.cs_4017 = 1'b0;
    idle(1);
    got = bus.data_out;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.data_out !== 8'h00 || bus.strobe_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data_out=%h strobe=%b, required 00/0", bus.data_out, bus.strobe_out);
    end
    checks++;
    if (dut.u_p1.r_state !== IDLE || dut.u_p1.r_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_fsm: state=%0d cnt=%0d, required IDLE/0", dut.u_p1.r_state, dut.u_p1.r_cnt);
    end
  endtask

  task automatic run_sequence(input string name, input int hold);
    logic [7:0] got;
    logic [9:0] exp_bits;
    logic [7:0] exp;
    logic       mb;
    exp_bits = 10'b11_0000_1001;  // D0 order 1,0,0,1,0,0,0,0 then fill 1,1
    do_kc(8'h09, 8'h00);
    do_write(1'b0, 8'h01);
    checks++;
    if (bus.strobe_out !== 1'b1) begin
      errors++;
      $display("FAIL %s_strobe_set: strobe_out=%b, required 1", name, bus.strobe_out);
    end
    do_write(1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      do_read(0, hold, 8'h40, got);
      mb  = model_read(0);
      exp = 8'h40 | {7'b0, exp_bits[i]};
      checks++;
      if (got !== exp || mb !== exp_bits[i]) begin
        errors++;
        $display("FAIL %s_read%0d: data_out=%h, required %h", name, i + 1, got, exp);
      end
    end
    checks++;
    if (dut.u_p1.r_cnt !== 4'd8) begin
      errors++;
      $display("FAIL %s_cnt_sat: cnt=%0d, required 8", name, dut.u_p1.r_cnt);
    end
  endtask

  task automatic test_load_and_read();
    run_sequence("load", 1);
  endtask

  task automatic test_long_strobes();
    run_sequence("long", 5);
  endtask

  task automatic test_strobe_high();
    logic [7:0] got;
    logic [7:0] exp;
    do_kc(8'h01, 8'h00);
    do_write(1'b0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) do_kc(8'h00, 8'h00);
      do_read(0, 1, 8'h00, got);
      exp = {7'b0, model_read(0)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL strobe_high_read%0d: data_out=%h, required %h", i + 1, got, exp);
      end
      checks++;
      if (dut.u_p1.r_cnt !== 4'd0) begin
        errors++;
        $display("FAIL strobe_high_cnt%0d: cnt=%0d, required 0", i + 1, dut.u_p1.r_cnt);
      end
    end
    do_write(1'b0, 8'h00);
  endtask

  task automatic test_port_independence();
    logic [7:0] got;
    int n1;
    n1 = 0;
    do_kc(8'hFF, 8'h00);
    do_write(1'b0, 8'h01);
    do_write(1'b0, 8'h00);
    do_write(1'b1, 8'h01);  // $4017 write is the APU's; must not touch strobe
    checks++;
    if (bus.strobe_out !== 1'b0) begin
      errors++;
      $display("FAIL indep_4017_write: strobe_out=%b, required 0", bus.strobe_out);
    end
    for (int i = 0; i < 5; i++) begin
      do_read(1, 1, 8'hFF, got);
      checks++;
      if (got !== 8'hE0 || model_read(1) !== 1'b0) begin
        errors++;
        $display("FAIL indep_4017_read%0d: data_out=%h, required e0", i + 1, got);
      end
      checks++;
      if (dut.u_p1.r_cnt !== 4'(n1)) begin
        errors++;
        $display("FAIL indep_p1_cnt%0d: cnt=%0d, required %0d", i + 1, dut.u_p1.r_cnt, n1);
      end
      do_read(0, 1, 8'h00, got);
      n1++;
      checks++;
      if (got !== 8'h01 || model_read(0) !== 1'b1) begin
        errors++;
        $display("FAIL indep_4016_read%0d: data_out=%h, required 01", i + 1, got);
      end
    end
  endtask

  task automatic test_mid_shift();
    logic [7:0] got;
    logic [7:0] exp;
    do_kc(8'hA5, 8'h3C);
    do_write(1'b0, 8'h01);
    do_write(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) do_kc(8'h5A, 8'hC3);
      do_read(0, 1, 8'h20, got);
      exp = 8'h20 | {7'b0, model_read(0)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_read%0d: data_out=%h, required %h", i + 1, got, exp);
      end
    end
    do_reset();
    checks++;
    if (bus.data_out !== 8'h00 || dut.u_p1.r_state !== IDLE) begin
      errors++;
      $display("FAIL mid_reset: data_out=%h state=%0d, required 00/IDLE", bus.data_out, dut.u_p1.r_state);
    end
    do_read(0, 1, 8'h00, got);
    checks++;
    if (got !== 8'h00 || model_read(0) !== 1'b0) begin
      errors++;
      $display("FAIL mid_post_reset_read: data_out=%h, required 00", got);
    end
  endtask

  task automatic test_rmw();
    logic [7:0] got;
    logic [7:0] exp;
    do_kc(8'h02, 8'h00);
    do_write(1'b0, 8'h01);
    do_write(1'b0, 8'h00);
    do_read(0, 1, 8'h00, got);
    void'(model_read(0));
    bus.open_bus_in = 8'h80;
    bus.cs_4016 = 1'b1; bus.rden = 1'b1; bus.wren = 1'b1; bus.data_in = 8'h01;
    idle(1);
    bus.cs_4016 = 1'b0; bus.rden = 1'b0; bus.wren = 1'b0;
    exp = 8'h80 | {7'b0, model_read(0)};
    model_write(1'b1);
    idle(2);
    got = bus.data_out;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rmw_read: data_out=%h, required %h", got, exp);
    end
    checks++;
    if (dut.u_p1.r_state !== LOAD || bus.strobe_out !== 1'b1) begin
      errors++;
      $display("FAIL rmw_load: state=%0d strobe=%b, required LOAD/1", dut.u_p1.r_state, bus.strobe_out);
    end
    do_write(1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] got;
    logic [7:0] exp;
    logic [7:0] ob;
    int op, port;
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 9);
      if (op == 0) do_write(1'($urandom_range(0, 1)), 8'($urandom));
      else if (op == 1) do_kc(8'($urandom), 8'($urandom));
      else begin
        port = $urandom_range(0, 1);
        ob   = 8'($urandom);
        do_read(port, $urandom_range(1, 4), ob, got);
        exp = (ob & 8'hE0) | {7'b0, model_read(port)};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random_read%0d port%0d: data_out=%h, required %h", i, port + 1, got, exp);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cs_4016 = 1'b0; bus.cs_4017 = 1'b0; bus.rden = 1'b0; bus.wren = 1'b0;
    bus.data_in = 8'h00; bus.open_bus_in = 8'h00;
    bus.kc_p1 = 8'h00; bus.kc_p2 = 8'h00; bus.kc_valid = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_and_read();
    test_long_strobes();
    test_strobe_high();
    test_port_independence();
    test_mid_shift();
    test_rmw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
